// File: rtl/pair_reader_pkg.sv
// Shared types and default pair window for the pair reader and the writer-side address counter.
package pair_reader_pkg;
  localparam int PAIR_W        = 13;
  localparam int ADDR_W        = 14;
  localparam int DEF_BASE_PAIR = 640;
  localparam int DEF_END_PAIR  = 768;

  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, SEND_A, SEND_B, DONE} state_t;
endpackage

// File: rtl/pair_addr_gen.sv
// Pair counter and even/odd word address formation for one sweep of the pair window.
module pair_addr_gen
  import pair_reader_pkg::*;
#(
  parameter int BASE_PAIR = DEF_BASE_PAIR,
  parameter int END_PAIR  = DEF_END_PAIR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  output logic              last,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b
);
  localparam logic [PAIR_W-1:0] BASE_P = PAIR_W'(BASE_PAIR);
  localparam logic [PAIR_W-1:0] LAST_P = PAIR_W'(END_PAIR - 1);

  logic [PAIR_W-1:0] pair;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pair <= BASE_P;
    else if (load) pair <= BASE_P;
    else if (inc)  pair <= pair + 1'b1;
  end

  // Caller only increments when last is low, so the counter never wraps.
  assign last   = (pair == LAST_P);
  assign addr_a = {pair, 1'b0};
  assign addr_b = {pair, 1'b1};
endmodule

// File: rtl/pair_reader.sv
// Sweeps a pair window out of a 1-cycle synchronous RAM and streams word(2p), word(2p+1) with valid/ready.
module pair_reader
  import pair_reader_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BASE_PAIR = DEF_BASE_PAIR,
  parameter int END_PAIR  = DEF_END_PAIR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] rdata_a,
  input  logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  generate
    if (!(BASE_PAIR >= 0 && BASE_PAIR < END_PAIR && END_PAIR <= 8192)) begin : g_bad_range
      $error("pair_reader: require 0 <= BASE_PAIR < END_PAIR <= 8192");
    end
  endgenerate

  state_t            state, state_n;
  logic              load, inc, last;
  logic              valid_n, busy_n, done_n;
  logic [DATA_W-1:0] word_a, word_b, wa_n, wb_n, data_n;

  pair_addr_gen #(.BASE_PAIR(BASE_PAIR), .END_PAIR(END_PAIR)) u_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .inc    (inc),
    .last   (last),
    .addr_a (addr_a),
    .addr_b (addr_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      word_a    <= '0;
      word_b    <= '0;
    end else begin
      state     <= state_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      busy      <= busy_n;
      done      <= done_n;
      word_a    <= wa_n;
      word_b    <= wb_n;
    end
  end

  always_comb begin
    state_n = state;
    valid_n = out_valid;
    data_n  = out_data;
    busy_n  = busy;
    done_n  = 1'b0;
    wa_n    = word_a;
    wb_n    = word_b;
    load    = 1'b0;
    inc     = 1'b0;
    case (state)
      IDLE: if (start) begin
        load    = 1'b1;
        busy_n  = 1'b1;
        state_n = WAIT;
      end
      // RAM samples the stable address on the edge leaving WAIT.
      WAIT: state_n = CAPTURE;
      CAPTURE: begin
        wa_n    = rdata_a;
        wb_n    = rdata_b;
        data_n  = rdata_a;
        valid_n = 1'b1;
        state_n = SEND_A;
      end
      SEND_A: if (out_ready) begin
        data_n  = word_b;
        state_n = SEND_B;
      end
      SEND_B: if (out_ready) begin
        valid_n = 1'b0;
        if (last) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          inc     = 1'b1;
          state_n = WAIT;
        end
      end
      DONE: begin
        load    = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
